adat_tdm_serializer: RTL
========================

// Module: adat_tdm_serializer
// PURPOSE
//  Converts the stream of parallel 24-bit audio samples from the USB-side sample FIFO
//  into the serial TDM8 stream (i2s_running/i2s_data) that the ADAT TX channel consumes.
//  Sits directly upstream of the ADAT TX channel, in its clock domain (1 clk = 1 ADAT bit).
//  Frames are 256 bits: 8 slots x 32 bits, 24-bit sample MSB-first then 8 zero bits.
//  Handles FIFO underrun and channel misalignment by muting until frame-realigned.
// PARAMETERS
//  SLOTS        8    channels per frame (fixed for ADAT; power of 2)
//  SLOT_BITS    32   bits per slot on the serial line
//  SAMPLE_BITS  24   sample width, left-justified in slot, remaining LSBs zero
// PORTS
//  clk_i           in   1   bit clock, shared with ADAT TX channel
//  rst_ni          in   1   asynchronous active-low reset
//  enable_i        in   1   start/stop request; stop honoured only at frame end
//  sample_i        in   24  sample data, channel order 0..7
//  sample_first_i  in   1   tags sample_i as channel 0 of a frame
//  sample_valid_i  in   1   sample_i/sample_first_i valid
//  sample_ready_o  out  1   sample accepted on edge where valid & ready
//  i2s_running_o   out  1   high for whole frames being transmitted
//  i2s_data_o      out  1   serial TDM data, MSB first
//  underrun_o      out  1   1-clk pulse: no sample in hold at a slot load
//  misalign_o      out  1   1-clk pulse: first tag mismatches slot index at load
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, hold empty, mute=0, counters 0; async assert, sync release.
//  Storage: 1-entry hold register {first,sample} + 32-bit shift register; bit_cnt[7:0].
//  sample_ready_o = (state!=IDLE) & ~hold_full (registered or comb from regs; no valid->ready path).
//  Accepted sample usable for loading from next edge. i2s_data_o = shift[31]; running = registered.
//  States:
//   IDLE : running=0, data=0. enable_i=1 -> PRIME.
//   PRIME: hold with first=0 is dropped (hold cleared same edge). enable_i=0 -> IDLE.
//          hold with first=1 -> RUN: shift<={sample,8'h0}, bit_cnt=0, hold cleared;
//          first bit on i2s_data_o and i2s_running_o=1 the following cycle.
//   RUN  : shift left each clk, bit_cnt++ (wraps 255->0). At bit_cnt[4:0]==31 load slot
//          k=bit_cnt[7:5]+1 mod 8 for next cycle per load rules. At bit_cnt==255 with
//          enable_i=0 -> IDLE: running_o=0, data_o=0 next cycle (exactly whole frames).
//  Load rules (not muted): hold empty -> load zeros, underrun_o pulse, mute=1.
//   k==0 & first=0, or k!=0 & first=1 -> load zeros, misalign_o pulse, mute=1;
//   first=1 sample stays in hold, first=0 sample discarded. Else load {sample,8'h0}, clear hold.
//  Muted: every slot loads zeros; hold with first=0 dropped immediately;
//   first=1 sample held and loaded at next k==0 slot, clearing mute. No pulses while muted.
//  Only one of underrun_o/misalign_o per load; both 0 otherwise.
//  Simultaneous accept and drop impossible (ready only when hold empty).
//  Reset mid-frame: outputs 0 immediately; after release restart from IDLE, no partial frame.
//  enable_i drop in PRIME aborts with no running pulse; hold contents retained.
// TESTING
//  1. Reset asserted mid-stream -> running/data/ready/pulses 0 same cycle; IDLE after release.
//  2. 16 samples ch n = 24'h800000|n, first on ch0, enable=1 -> 512 running clks; slot n
//     bits = 24'h80000n MSB-first + 8 zeros; ready never stalls feed.
//  3. Withhold frame0 ch3 -> underrun_o pulse at bit_cnt 95, slots 3..7 zero, frame1 correct
//     after first-tagged sample; no further pulses.
//  4. first_i=1 presented as frame0 ch5 -> misalign_o pulse at bit_cnt 159, slots 5..7 zero,
//     that sample emitted in frame1 slot0.
//  5. enable_i=0 at bit_cnt 100 -> frame completes; running_o falls after bit 255 (256 bits).
//  6. Only first=0 samples in PRIME -> all dropped, running_o stays 0; then first=1 -> start.

Source files
------------

// File: rtl/adat_tdm_serializer.sv
// adat_tdm_serializer
// Turns parallel 24-bit samples from the USB-side FIFO into the 256-bit TDM8
// frame stream (8 slots x 32 bits, sample MSB-first then zero pad) consumed by
// the ADAT TX channel. One clock equals one serial bit. Underruns and channel
// misalignment mute the output until a first-tagged sample lines up with slot 0.
module adat_tdm_serializer #(
    parameter int SLOTS       = 8,
    parameter int SLOT_BITS   = 32,
    parameter int SAMPLE_BITS = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic [SAMPLE_BITS-1:0] sample_i,
    input  logic                   sample_first_i,
    input  logic                   sample_valid_i,
    output logic                   sample_ready_o,
    output logic                   i2s_running_o,
    output logic                   i2s_data_o,
    output logic                   underrun_o,
    output logic                   misalign_o
);

    localparam int SLOT_W   = $clog2(SLOTS);
    localparam int BIT_W    = $clog2(SLOT_BITS);
    localparam int CNT_W    = SLOT_W + BIT_W;
    localparam int PAD_BITS = SLOT_BITS - SAMPLE_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   holdFull_q, holdFull_d;
    logic                   holdFirst_q, holdFirst_d;
    logic [SAMPLE_BITS-1:0] holdSample_q, holdSample_d;
    logic [SLOT_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
    logic                   mute_q, mute_d;
    logic                   running_q, running_d;

    logic                   sampleReady;
    logic                   sampleAccept;
    logic                   slotLoad;
    logic                   frameEnd;
    logic [SLOT_W-1:0]      slotIdx;
    logic                   holdClear;
    logic                   underrunPulse;
    logic                   misalignPulse;
    logic [SLOT_BITS-1:0]   holdWord;

    // Ready depends only on registered state, so there is no valid->ready path.
    assign sampleReady  = (state_q != IDLE) && !holdFull_q;
    assign sampleAccept = sample_valid_i && sampleReady;

    // Last bit of a slot is on the line: the next slot is loaded on this edge.
    assign slotLoad = (bitCnt_q[BIT_W-1:0] == {BIT_W{1'b1}});
    assign frameEnd = (bitCnt_q == {CNT_W{1'b1}});
    assign slotIdx  = bitCnt_q[CNT_W-1:BIT_W] + SLOT_W'(1);
    assign holdWord = {holdSample_q, {PAD_BITS{1'b0}}};

    // Next-state logic: sequencing, slot loading rules, mute handling and the hold register.
    always_comb begin
        state_d       = state_q;
        holdFull_d    = holdFull_q;
        holdFirst_d   = holdFirst_q;
        holdSample_d  = holdSample_q;
        shift_d       = shift_q;
        bitCnt_d      = bitCnt_q;
        mute_d        = mute_q;
        running_d     = running_q;
        holdClear     = 1'b0;
        underrunPulse = 1'b0;
        misalignPulse = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = PRIME;
                end
            end

            PRIME: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (holdFull_q) begin
                    holdClear = 1'b1;
                    if (holdFirst_q) begin
                        state_d   = RUN;
                        shift_d   = holdWord;
                        bitCnt_d  = '0;
                        running_d = 1'b1;
                        mute_d    = 1'b0;
                    end
                end
            end

            RUN: begin
                bitCnt_d = bitCnt_q + CNT_W'(1);
                shift_d  = {shift_q[SLOT_BITS-2:0], 1'b0};
                if (frameEnd && !enable_i) begin
                    state_d   = IDLE;
                    running_d = 1'b0;
                    shift_d   = '0;
                end else if (slotLoad) begin
                    shift_d = '0;
                    if (mute_q) begin
                        if (holdFull_q && holdFirst_q && (slotIdx == '0)) begin
                            shift_d   = holdWord;
                            holdClear = 1'b1;
                            mute_d    = 1'b0;
                        end else if (holdFull_q && !holdFirst_q) begin
                            holdClear = 1'b1;
                        end
                    end else if (!holdFull_q) begin
                        underrunPulse = 1'b1;
                        mute_d        = 1'b1;
                    end else if ((slotIdx == '0) != holdFirst_q) begin
                        misalignPulse = 1'b1;
                        mute_d        = 1'b1;
                        if (!holdFirst_q) begin
                            holdClear = 1'b1;
                        end
                    end else begin
                        shift_d   = holdWord;
                        holdClear = 1'b1;
                    end
                end else if (mute_q && holdFull_q && !holdFirst_q) begin
                    holdClear = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (holdClear) begin
            holdFull_d = 1'b0;
        end
        if (sampleAccept) begin
            holdFull_d   = 1'b1;
            holdFirst_d  = sample_first_i;
            holdSample_d = sample_i;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            holdFull_q   <= 1'b0;
            holdFirst_q  <= 1'b0;
            holdSample_q <= '0;
            shift_q      <= '0;
            bitCnt_q     <= '0;
            mute_q       <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            holdFull_q   <= holdFull_d;
            holdFirst_q  <= holdFirst_d;
            holdSample_q <= holdSample_d;
            shift_q      <= shift_d;
            bitCnt_q     <= bitCnt_d;
            mute_q       <= mute_d;
            running_q    <= running_d;
        end
    end

    assign sample_ready_o = sampleReady;
    assign i2s_running_o  = running_q;
    assign i2s_data_o     = shift_q[SLOT_BITS-1];
    assign underrun_o     = underrunPulse;
    assign misalign_o     = misalignPulse;

endmodule
